// File: rtl/cc_event_arbiter.sv
// Round-robin arbiter that multiplexes N source-domain event requesters onto one
// single-bit cross-clock handshake channel, tagging each launched pulse with its source.
module cc_event_arbiter #(
  parameter int N     = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            ovf_clr,
  output logic            ch_in,
  input  logic            ch_busy,
  output logic [ID_W-1:0] ch_tag,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    ovf,
  output logic            err_proto,
  output logic            idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [N];
  logic [CNT_W-1:0]  cnt_d [N];
  logic [N-1:0]      ovf_q, ovf_d;
  logic [N-1:0]      nz;
  logic [N-1:0]      dec;
  logic              err_q, err_d;
  logic              ch_in_q, ch_in_d;
  logic [ID_W-1:0]   tag_q, tag_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   grant;
  logic              found;
  logic              launch;
  int                idx;

  // Saturating pending-count update; a simultaneous request and launch cancel out.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc,
                                                input logic dc);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dc) begin
      r = (c == CNT_MAX) ? c : c + 1'b1;
    end else if (dc && !inc) begin
      r = c - 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      nz[i] = (cnt_q[i] != '0);
    end
  end

  // Search starts just after the last granted source so every requester is reached within N launches.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_q) + k) % N;
      if (!found && nz[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (!ch_busy && found) begin
          launch  = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_ARM;
      S_ARM: begin
        // The channel must acknowledge the pulse; if not, flag it and drop the event.
        if (!ch_busy) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!ch_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_in_d = launch;
    tag_d   = launch ? grant : tag_q;
    rr_d    = launch ? grant : rr_q;
    for (int i = 0; i < N; i++) begin
      dec[i] = launch && (grant == ID_W'(i));
    end
  end

  always_comb begin
    ovf_d = ovf_q & ~{N{ovf_clr}};
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_next(cnt_q[i], req[i], dec[i]);
      if (req[i] && !dec[i] && (cnt_q[i] == CNT_MAX)) begin
        ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ovf_q   <= '0;
      err_q   <= 1'b0;
      ch_in_q <= 1'b0;
      tag_q   <= '0;
      rr_q    <= ID_W'(N - 1);
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ch_in_q <= ch_in_d;
      tag_q   <= tag_d;
      rr_q    <= rr_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ch_in     = ch_in_q;
  assign ch_tag    = tag_q;
  assign pending   = nz;
  assign ovf       = ovf_q;
  assign err_proto = err_q;
  assign idle      = (state_q == S_IDLE) && !(|nz);

endmodule

// File: tb/tb_cc_event_arbiter.sv
// Directed bench for cc_event_arbiter with a simple channel responder that
// raises busy the cycle after each pulse and holds it for busy_len cycles.
module tb_cc_event_arbiter;
  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic            ovf_clr;
  logic            ch_in;
  logic            ch_busy;
  logic [ID_W-1:0] ch_tag;
  logic [N-1:0]    pending;
  logic [N-1:0]    ovf;
  logic            err_proto;
  logic            idle;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  cc_event_arbiter #(.N(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ovf_clr  (ovf_clr),
    .ch_in    (ch_in),
    .ch_busy  (ch_busy),
    .ch_tag   (ch_tag),
    .pending  (pending),
    .ovf      (ovf),
    .err_proto(err_proto),
    .idle     (idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel responder; force_en overrides busy for gating and stub tests.
  int   busy_len  = 3;
  int   busy_cnt  = 0;
  logic force_en  = 1'b0;
  logic force_val = 1'b0;
  always @(posedge clk) begin
    if (ch_in) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign ch_busy = force_en ? force_val : (busy_cnt != 0);

  // Launch monitor with protocol invariants.
  int              launches = 0;
  logic [ID_W-1:0] tags[$];
  logic            chin_at_edge = 1'b0;
  logic            busy_at_edge = 1'b0;
  always @(posedge clk) begin
    chin_at_edge <= ch_in;
    busy_at_edge <= ch_busy;
  end
  always @(negedge clk) begin
    if (ch_in) begin
      launches++;
      tags.push_back(ch_tag);
      chk("no_b2b_ch_in", {31'b0, chin_at_edge}, 0);
      chk("no_launch_busy", {31'b0, busy_at_edge}, 0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; req = '0; ovf_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      step();
      if (idle && !ch_busy && !ch_in) done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, lw, s;
    rst = 1'b1; req = '0; ovf_clr = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ch_in", ch_in, 0);
    chk("rst_ch_tag", ch_tag, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err_proto, 0);
    chk("rst_idle", idle, 1);

    // 1. Single event
    l0 = launches;
    req = 4'b0100;
    step(); req = '0;
    chk("t1_pending", pending, 4'b0100);
    chk("t1_ch_in_early", ch_in, 0);
    chk("t1_idle_busy", idle, 0);
    step();
    chk("t1_ch_in", ch_in, 1);
    chk("t1_tag", ch_tag, 2);
    wait_idle("t1", 50);
    chk("t1_count", launches - l0, 1);
    chk("t1_idle", idle, 1);
    chk("t1_err", err_proto, 0);

    // 2. Fairness and saturation
    do_reset();
    l0 = launches; s = tags.size();
    for (int i = 0; i < 20; i++) begin
      req = 4'b1111;
      step();
    end
    req = '0;
    lw = launches;
    chk("t2_ovf", ovf, 4'b1111);
    chk("t2_pending", pending, 4'b1111);
    wait_idle("t2", 2000);
    chk("t2_after_count", launches - lw, 60);
    for (int k = 0; k < launches - l0; k++) begin
      chk("t2_rr_tag", tags[s + k], k % 4);
    end
    ovf_clr = 1'b1;
    step(); ovf_clr = 1'b0;
    chk("t2_ovf_clr", ovf, 0);

    // 3. Same-cycle increment and decrement
    do_reset();
    l0 = launches; s = tags.size();
    req = 4'b0010;
    step();
    step(); req = '0;
    chk("t3_ch_in", ch_in, 1);
    chk("t3_tag", ch_tag, 1);
    chk("t3_pending", pending, 4'b0010);
    wait_idle("t3", 100);
    chk("t3_count", launches - l0, 2);
    chk("t3_tag2", tags[s + 1], 1);

    // 4. Busy gating
    do_reset();
    force_en = 1'b1; force_val = 1'b1;
    l0 = launches; s = tags.size();
    for (int i = 0; i < 3; i++) begin
      req = 4'b0001;
      step();
    end
    req = '0;
    repeat (5) step();
    chk("t4_no_launch", launches - l0, 0);
    chk("t4_pending", pending, 4'b0001);
    force_en = 1'b0;
    step();
    chk("t4_ch_in", ch_in, 1);
    chk("t4_tag", ch_tag, 0);
    wait_idle("t4", 100);
    chk("t4_count", launches - l0, 3);

    // 5. Protocol error with channel busy stuck low
    do_reset();
    force_en = 1'b1; force_val = 1'b0;
    l0 = launches;
    req = 4'b1000;
    step(); req = '0;
    step();
    chk("t5_ch_in", ch_in, 1);
    chk("t5_tag", ch_tag, 3);
    step();
    chk("t5_arm_ch_in", ch_in, 0);
    chk("t5_arm_err", err_proto, 0);
    step();
    chk("t5_err", err_proto, 1);
    chk("t5_idle", idle, 1);
    repeat (5) step();
    chk("t5_count", launches - l0, 1);
    chk("t5_err_sticky", err_proto, 1);
    force_en = 1'b0;
    wait_idle("t5", 20);

    // 6. Reset while waiting on the channel
    do_reset();
    busy_len = 6;
    l0 = launches;
    req = 4'b1010;
    step();
    step(); req = '0;
    step();
    step();
    chk("t6_pending_wait", pending, 4'b1010);
    chk("t6_tag_wait", ch_tag, 1);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("t6_rst_ch_in", ch_in, 0);
    chk("t6_rst_tag", ch_tag, 0);
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_err", err_proto, 0);
    chk("t6_rst_idle", idle, 1);
    repeat (12) step();
    chk("t6_no_more", launches - l0, 1);
    chk("t6_idle", idle, 1);
    busy_len = 3;

    // 7. Overflow clear racing a fresh overflow
    do_reset();
    force_en = 1'b1; force_val = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req = 4'b0001;
      step();
    end
    chk("t7_ovf_set", ovf, 4'b0001);
    ovf_clr = 1'b1;
    step();
    chk("t7_ovf_wins", ovf, 4'b0001);
    req = '0;
    step(); ovf_clr = 1'b0;
    chk("t7_ovf_cleared", ovf, 0);
    do_reset();
    force_en = 1'b0;
    chk("t7_rst_pending", pending, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
